// File: rtl/bt656_stream_rx_if.sv
// Byte-stream input and decoded pixel/status output bundle of the BT.656 receiver.
// The master side feeds stream bytes; the slave side is the decoder.
interface bt656_stream_rx_if #(
    parameter int PIX_CNT_W  = 12,
    parameter int LINE_CNT_W = 11
);
    logic                  data_en_i;
    logic [7:0]            data_i;
    logic                  pix_valid_o;
    logic [15:0]           pix_data_o;
    logic                  pix_cr_o;
    logic                  sof_o;
    logic                  sav_o;
    logic                  eav_o;
    logic                  field_o;
    logic                  vblank_o;
    logic                  hblank_o;
    logic                  hdr_err_o;
    logic                  locked_o;
    logic [PIX_CNT_W-1:0]  line_pixels_o;
    logic [LINE_CNT_W-1:0] field_lines_o;

    modport master (
        output data_en_i, data_i,
        input  pix_valid_o, pix_data_o, pix_cr_o, sof_o, sav_o, eav_o,
               field_o, vblank_o, hblank_o, hdr_err_o, locked_o,
               line_pixels_o, field_lines_o
    );

    modport slave (
        input  data_en_i, data_i,
        output pix_valid_o, pix_data_o, pix_cr_o, sof_o, sav_o, eav_o,
               field_o, vblank_o, hblank_o, hdr_err_o, locked_o,
               line_pixels_o, field_lines_o
    );
endinterface

// File: rtl/bt656_stream_rx.sv
// ITU-R BT.656 byte-stream decoder: timing-reference hunting, XY checking,
// {C,Y} pixel packing and line/field size measurement.
module bt656_stream_rx #(
    parameter int PIX_CNT_W  = 12,
    parameter int LINE_CNT_W = 11
) (
    input  logic                   clk,
    input  logic                   rstn,
    bt656_stream_rx_if.slave       bus
);

    typedef enum logic [2:0] {
        S_BLANK,
        S_ACTIVE,
        S_P1,
        S_P2,
        S_P3
    } state_t;

    state_t                state;
    logic                  phase;
    logic                  chroma_cr;
    logic                  prev_v;
    logic                  sof_pend;
    logic [7:0]            c_byte;
    logic [PIX_CNT_W-1:0]  pix_cnt;
    logic [LINE_CNT_W-1:0] line_cnt;

    logic xy_f, xy_v, xy_h, xy_ok;

    assign xy_f  = bus.data_i[6];
    assign xy_v  = bus.data_i[5];
    assign xy_h  = bus.data_i[4];
    assign xy_ok = bus.data_i[7]
                 && (bus.data_i[3] == (xy_v ^ xy_h))
                 && (bus.data_i[2] == (xy_f ^ xy_h))
                 && (bus.data_i[1] == (xy_f ^ xy_v))
                 && (bus.data_i[0] == (xy_f ^ xy_v ^ xy_h));

    // A header error also discards the partial line so a following EAV does not commit it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state             <= S_BLANK;
            phase             <= 1'b0;
            chroma_cr         <= 1'b0;
            prev_v            <= 1'b1;
            sof_pend          <= 1'b0;
            c_byte            <= '0;
            pix_cnt           <= '0;
            line_cnt          <= '0;
            bus.pix_valid_o   <= 1'b0;
            bus.pix_data_o    <= '0;
            bus.pix_cr_o      <= 1'b0;
            bus.sof_o         <= 1'b0;
            bus.sav_o         <= 1'b0;
            bus.eav_o         <= 1'b0;
            bus.field_o       <= 1'b0;
            bus.vblank_o      <= 1'b0;
            bus.hblank_o      <= 1'b0;
            bus.hdr_err_o     <= 1'b0;
            bus.locked_o      <= 1'b0;
            bus.line_pixels_o <= '0;
            bus.field_lines_o <= '0;
        end else begin
            bus.pix_valid_o <= 1'b0;
            bus.sof_o       <= 1'b0;
            bus.sav_o       <= 1'b0;
            bus.eav_o       <= 1'b0;
            bus.hdr_err_o   <= 1'b0;

            if (bus.data_en_i) begin
                if (bus.data_i == 8'hFF) begin
                    state <= S_P1;
                end else begin
                    case (state)
                        S_BLANK: begin
                            state <= S_BLANK;
                        end

                        S_ACTIVE: begin
                            if (!phase) begin
                                c_byte <= bus.data_i;
                                phase  <= 1'b1;
                            end else begin
                                phase           <= 1'b0;
                                bus.pix_valid_o <= 1'b1;
                                bus.pix_data_o  <= {c_byte, bus.data_i};
                                bus.pix_cr_o    <= chroma_cr;
                                bus.sof_o       <= sof_pend;
                                sof_pend        <= 1'b0;
                                chroma_cr       <= ~chroma_cr;
                                if (pix_cnt != '1)
                                    pix_cnt <= pix_cnt + PIX_CNT_W'(1);
                            end
                        end

                        S_P1, S_P2: begin
                            if (bus.data_i == 8'h00) begin
                                state <= (state == S_P1) ? S_P2 : S_P3;
                            end else begin
                                state         <= S_BLANK;
                                bus.hdr_err_o <= 1'b1;
                                bus.locked_o  <= 1'b0;
                                pix_cnt       <= '0;
                            end
                        end

                        S_P3: begin
                            if (!xy_ok) begin
                                state         <= S_BLANK;
                                bus.hdr_err_o <= 1'b1;
                                bus.locked_o  <= 1'b0;
                                pix_cnt       <= '0;
                            end else begin
                                bus.field_o  <= xy_f;
                                bus.vblank_o <= xy_v;
                                bus.hblank_o <= xy_h;
                                if (xy_h) begin
                                    state        <= S_BLANK;
                                    bus.eav_o    <= 1'b1;
                                    bus.locked_o <= 1'b1;
                                    pix_cnt      <= '0;
                                    prev_v       <= xy_v;
                                    if (!xy_v && (pix_cnt != '0)) begin
                                        bus.line_pixels_o <= pix_cnt;
                                        line_cnt          <= line_cnt + LINE_CNT_W'(1);
                                    end
                                    if (xy_v && !prev_v) begin
                                        bus.field_lines_o <= line_cnt;
                                        line_cnt          <= '0;
                                    end
                                end else begin
                                    bus.sav_o <= 1'b1;
                                    if (!xy_v) begin
                                        state     <= S_ACTIVE;
                                        phase     <= 1'b0;
                                        chroma_cr <= 1'b0;
                                        pix_cnt   <= '0;
                                        sof_pend  <= prev_v;
                                    end else begin
                                        state <= S_BLANK;
                                    end
                                end
                            end
                        end

                        default: begin
                            state <= S_BLANK;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bt656_stream_rx.sv
// Randomized frame-level bench for bt656_stream_rx: a line/frame model predicts
// pixels, pulses and measurements from the stream it generates.
module tb_bt656_stream_rx;

    logic clk;
    logic rstn;
    int   cyc;
    bit   throttle;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic [15:0] data;
        logic        cr;
        logic        sof;
        int          cyc;
    } pix_t;

    pix_t exp_q[$];

    int  exp_line_pixels, exp_field_lines, line_count;
    bit  prev_v, exp_locked;
    int  exp_sav, exp_eav, exp_err, exp_sof;
    int  seen_sav, seen_eav, seen_err, seen_sof;

    bt656_stream_rx_if bus ();

    bt656_stream_rx dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [48:0] all_outputs;
    assign all_outputs = {bus.pix_valid_o, bus.pix_data_o, bus.pix_cr_o, bus.sof_o,
                          bus.sav_o, bus.eav_o, bus.field_o, bus.vblank_o, bus.hblank_o,
                          bus.hdr_err_o, bus.locked_o, bus.line_pixels_o, bus.field_lines_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach the end (cycle %0d, want < 200000)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled on the falling edge, half a cycle after the updating edge.
    always @(negedge clk) begin : monitor
        pix_t e;
        if (bus.pix_valid_o) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pix", 64'(bus.pix_data_o), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pix_data", 64'(bus.pix_data_o), 64'(e.data));
                checkOutput("pix_cr", 64'(bus.pix_cr_o), 64'(e.cr));
                checkOutput("pix_sof", 64'(bus.sof_o), 64'(e.sof));
                checkOutput("pix_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (bus.sof_o) begin
            checkOutput("sof_without_pix", 64'(bus.sof_o), 64'd0);
        end
        if (bus.sav_o)     seen_sav++;
        if (bus.eav_o)     seen_eav++;
        if (bus.hdr_err_o) seen_err++;
        if (bus.sof_o)     seen_sof++;
    end

    task automatic applyIdle();
        @(negedge clk);
        bus.data_en_i = 1'b0;
        bus.data_i    = 8'($urandom);
    endtask

    // Returns the clock number at which the byte is sampled.
    task automatic applyStimulus(input logic [7:0] b, output int sc);
        if (throttle) begin
            for (int i = 0; i < 4 && $urandom_range(1, 0) == 1; i++)
                applyIdle();
        end
        @(negedge clk);
        bus.data_en_i = 1'b1;
        bus.data_i    = b;
        sc            = cyc + 1;
    endtask

    function automatic logic [7:0] make_xy(input bit f, input bit v, input bit h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    task automatic send_hdr(input bit f, input bit v, input bit h, input bit bad);
        int sc;
        logic [7:0] xy;
        xy = make_xy(f, v, h);
        if (bad) xy = xy ^ 8'h01;
        applyStimulus(8'hFF, sc);
        applyStimulus(8'h00, sc);
        applyStimulus(8'h00, sc);
        applyStimulus(xy, sc);
    endtask

    task automatic do_reset();
        applyIdle();
        applyIdle();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midline_reset_outputs", 64'(all_outputs), 64'd0);
        rstn = 1'b1;
        prev_v          = 1'b1;
        line_count      = 0;
        exp_line_pixels = 0;
        exp_field_lines = 0;
        exp_locked      = 1'b0;
    endtask

    // mode: 0 clean, 1 corrupted SAV parity, 2 broken preamble after k pixels, 3 reset after k pixels
    task automatic send_line(input int ln, input bit f, input bit v, input int mode,
                             input int k, input bit force_pat);
        int sc, npix;
        bit active, sof_line;
        logic [7:0] c, y;
        npix     = 0;
        active   = 1'b0;
        sof_line = 1'b0;

        if (mode == 1) begin
            send_hdr(f, v, 1'b0, 1'b1);
            applyIdle();
            exp_err++;
            exp_locked = 1'b0;
            checkOutput($sformatf("L%0d_parity_hdr_err", ln), 64'(bus.hdr_err_o), 64'd1);
            checkOutput($sformatf("L%0d_parity_locked", ln), 64'(bus.locked_o), 64'd0);
        end else begin
            send_hdr(f, v, 1'b0, 1'b0);
            exp_sav++;
            if (!v) begin
                active   = 1'b1;
                sof_line = prev_v;
            end
        end

        for (int p = 0; p < 20; p++) begin
            if (mode == 2 && p == k) begin
                applyStimulus(8'hFF, sc);
                applyStimulus(8'h00, sc);
                applyStimulus(8'h37, sc);
                applyIdle();
                exp_err++;
                exp_locked = 1'b0;
                active     = 1'b0;
                npix       = 0;
                checkOutput($sformatf("L%0d_preamble_hdr_err", ln), 64'(bus.hdr_err_o), 64'd1);
                checkOutput($sformatf("L%0d_preamble_locked", ln), 64'(bus.locked_o), 64'd0);
                checkOutput($sformatf("L%0d_preamble_line_pixels", ln),
                            64'(bus.line_pixels_o), 64'(exp_line_pixels));
            end
            if (mode == 3 && p == k) begin
                do_reset();
                active = 1'b0;
                npix   = 0;
            end
            c = 8'($urandom_range(254, 1));
            y = 8'($urandom_range(254, 1));
            if (force_pat && p == 0) begin c = 8'h55; y = 8'h11; end
            if (force_pat && p == 1) begin c = 8'h66; y = 8'h22; end
            applyStimulus(c, sc);
            applyStimulus(y, sc);
            if (active) begin
                exp_q.push_back('{data: {c, y}, cr: npix[0], sof: (sof_line && npix == 0), cyc: sc});
                if (sof_line && npix == 0) exp_sof++;
                npix++;
            end
        end

        send_hdr(f, v, 1'b1, 1'b0);
        exp_eav++;
        exp_locked = 1'b1;
        if (!v && npix > 0) begin
            exp_line_pixels = npix;
            line_count++;
        end
        if (v && !prev_v) begin
            exp_field_lines = line_count;
            line_count      = 0;
        end
        prev_v = v;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h80, sc);
            applyStimulus(8'h10, sc);
        end
        applyIdle();

        checkOutput($sformatf("L%0d_field", ln), 64'(bus.field_o), 64'(f));
        checkOutput($sformatf("L%0d_vblank", ln), 64'(bus.vblank_o), 64'(v));
        checkOutput($sformatf("L%0d_hblank", ln), 64'(bus.hblank_o), 64'd1);
        checkOutput($sformatf("L%0d_locked", ln), 64'(bus.locked_o), 64'(exp_locked));
        checkOutput($sformatf("L%0d_line_pixels", ln), 64'(bus.line_pixels_o), 64'(exp_line_pixels));
        checkOutput($sformatf("L%0d_field_lines", ln), 64'(bus.field_lines_o), 64'(exp_field_lines));
    endtask

    task automatic send_frame(input int err_a, input int mode_a, input int err_b, input int mode_b,
                              input int k, input bit force_pat);
        bit f, v;
        int mode;
        for (int ln = 1; ln <= 16; ln++) begin
            f    = (ln >= 9);
            v    = !((ln >= 3 && ln <= 6) || (ln >= 11 && ln <= 14));
            mode = (ln == err_a) ? mode_a : ((ln == err_b) ? mode_b : 0);
            send_line(ln, f, v, mode, k, force_pat && ln == 3);
        end
    endtask

    initial begin
        n_compared      = 0;
        n_mismatched    = 0;
        throttle        = 1'b0;
        prev_v          = 1'b1;
        exp_locked      = 1'b0;
        line_count      = 0;
        exp_line_pixels = 0;
        exp_field_lines = 0;
        rstn            = 1'b0;
        bus.data_en_i   = 1'b0;
        bus.data_i      = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 64'(all_outputs), 64'd0);
        rstn = 1'b1;

        $display("[TB] clean frame with fixed packing pattern");
        send_frame(0, 0, 0, 0, 0, 1'b1);

        $display("[TB] throttled clean frame");
        throttle = 1'b1;
        send_frame(0, 0, 0, 0, 0, 1'b0);
        throttle = 1'b0;

        $display("[TB] parity error on line 4, broken preamble on line 12");
        send_frame(4, 1, 12, 2, 7, 1'b0);

        $display("[TB] reset in the middle of line 6");
        send_frame(6, 3, 0, 0, 9, 1'b0);

        $display("[TB] throttled clean frame after errors");
        throttle = 1'b1;
        send_frame(0, 0, 0, 0, 0, 1'b0);
        throttle = 1'b0;

        repeat (3) applyIdle();

        checkOutput("pending_pixels", 64'(exp_q.size()), 64'd0);
        checkOutput("sav_pulses", 64'(seen_sav), 64'(exp_sav));
        checkOutput("eav_pulses", 64'(seen_eav), 64'(exp_eav));
        checkOutput("hdr_err_pulses", 64'(seen_err), 64'(exp_err));
        checkOutput("sof_pulses", 64'(seen_sof), 64'(exp_sof));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bt656_stream_rx.md
Name: bt656_stream_rx

Overview:
Receiver/decoder for an 8-bit ITU-R BT.656 byte stream, such as the camera-side output that feeds the FPGA video path.
- Hunts for FF 00 00 XY timing reference codes and checks the XY protection bits.
- Tracks field, vertical-blanking and horizontal-blanking state.
- Packs active-video bytes into 16-bit {chroma, luma} pixels with valid strobes.
- Measures line length and field height for downstream capture/DMA logic and status registers.

Parameters:
PIX_CNT_W, 12, width of per-line pixel counter and line_pixels_o.
LINE_CNT_W, 11, width of per-field active-line counter and field_lines_o.

Ports:
clk  in  1  clock; one stream byte may be sampled per rising edge.
rstn  in  1  reset, synchronous, active-low.
data_en_i  in  1  qualifies data_i; bytes with data_en_i=0 are ignored and state holds.
data_i  in  8  BT.656 byte stream.
pix_valid_o  out  1  one-cycle strobe; pix_data_o holds a pixel.
pix_data_o  out  16  {C[7:0], Y[7:0]}.
pix_cr_o  out  1  C is Cr (1) or Cb (0); valid with pix_valid_o.
sof_o  out  1  with the first pix_valid_o of a field's first active line.
sav_o  out  1  pulse on accepted SAV.
eav_o  out  1  pulse on accepted EAV.
field_o  out  1  F of last accepted header.
vblank_o  out  1  V of last accepted header.
hblank_o  out  1  H of last accepted header.
hdr_err_o  out  1  pulse on bad XY parity or broken preamble.
locked_o  out  1  a valid EAV has been seen since the last error.
line_pixels_o  out  PIX_CNT_W  pixel count of the last completed active line.
field_lines_o  out  LINE_CNT_W  active-line count of the last completed field.

Behaviour:
- All outputs are registered. Under rstn=0: all outputs are 0 and the FSM is in S_BLANK.
- Internal state cleared under reset: counters, byte phase, chroma toggle, prev_v (=1).
- FSM states: S_BLANK, S_ACTIVE, S_P1 (FF seen), S_P2 (FF 00), S_P3 (FF 00 00). Transitions occur only on data_en_i=1.
- Any state, byte FF -> S_P1. FF never appears in legal video data.
- S_P1: 00 -> S_P2; else hdr_err_o, -> S_BLANK.
- S_P2: 00 -> S_P3; else hdr_err_o, -> S_BLANK.
- S_P3: byte is XY = {1, F, V, H, P3, P2, P1, P0}.
  - Valid iff bit7=1, P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
  - Invalid: hdr_err_o=1, locked_o<=0, field/vblank/hblank hold, -> S_BLANK.
- Valid XY updates field_o, vblank_o, hblank_o the cycle after the XY byte, then:
  - H=1 (EAV): eav_o, locked_o<=1, -> S_BLANK.
    - If the ended line was active (V=0) and its pixel count >0: line_pixels_o <= pixel count, active-line counter +1.
    - If V=1 and prev_v=0: field_lines_o <= active-line count, count cleared.
    - prev_v <= V.
  - H=0 (SAV): sav_o.
    - V=0: -> S_ACTIVE; byte phase, chroma toggle and pixel count cleared.
    - V=1: -> S_BLANK.
- S_BLANK: non-FF bytes discarded.
- S_ACTIVE: even phase byte captured as C; odd phase byte forms a pixel.
  - Next cycle: pix_valid_o=1, pix_data_o={C,Y}, pix_cr_o=toggle. Toggle flips, pixel count +1 (saturates at all-ones).
  - Chroma order per line: Cb, Cr, Cb, ...
  - Latency: 1 clk from the Y byte edge to pix_valid_o.
  - An unpaired trailing C before FF is dropped.
- sof_o: asserted with the first pixel of an active line whose SAV followed a line with prev_v=1. Also asserted on the first active line after lock when prev_v reset=1.
- Pulse outputs are 1 cycle wide and occur the cycle after the triggering byte.
- Reset mid-line: output resumes only after the next valid SAV with V=0.
- data_en_i gaps inside the preamble or mid-pixel are legal; state holds.

Test Plan:
- Clean stream: 16-line frame, 10 blanking pairs + 20 pixels/line, active lines 3-6 (F=0) and 11-14 (F=1); headers 80/9D, AB/B6, C7/DA.
  - Expect 20 pix_valid_o per active line, line_pixels_o=20, field_lines_o=4.
  - sof_o twice per frame; field_o toggles at line 9.
- Pixel packing: active bytes 55,11,66,22 -> pixels {55,11} pix_cr_o=0, then {66,22} pix_cr_o=1, each 1 clk after the Y byte.
- Parity error: send FF 00 00 81 in place of SAV 80 -> hdr_err_o pulse, locked_o=0, no pixels that line; next valid EAV 9D -> locked_o=1.
- Broken preamble: FF 00 37 mid-active -> hdr_err_o, S_BLANK, line_pixels_o unchanged.
- Throttling: same clean frame with data_en_i=0 on random 50% of cycles -> identical pixel sequence and counts.
- Reset mid-active-line: rstn=0 for 2 clk -> all outputs 0; no pix_valid_o until next SAV 80/C7.
